// File: rtl/pack_test_pkg.sv
// Shared definitions for the ice40 packing-test stimulus/monitor harness.
//   state_t           : run sequencer states
//   LFSR_TAPS         : Galois feedback mask of the 16-bit stimulus LFSR
//   MISR_POLY_DEFAULT : default signature feedback polynomial
//   lfsr_next()       : one right-shift Galois step of the stimulus LFSR
//   misr_next()       : one compaction step of the 32-bit signature register
package pack_test_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DUT_RST = 3'd1,
        RUN     = 3'd2,
        DRAIN   = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [31:0] MISR_POLY_DEFAULT = 32'h04C11DB7;

    function automatic logic [15:0] lfsr_next(input logic [15:0] value);
        return (value >> 1) ^ (value[0] ? LFSR_TAPS : 16'h0000);
    endfunction

    // taps = {outd, outc, outb, outa}; they fold into the low four bits.
    function automatic logic [31:0] misr_next(input logic [31:0] sig,
                                              input logic [3:0]  taps,
                                              input logic [31:0] poly = MISR_POLY_DEFAULT);
        return {sig[30:0], 1'b0} ^ (sig[31] ? poly : 32'h0) ^ {28'b0, taps};
    endfunction

endpackage

// File: rtl/pack_misr32.sv
// 32-bit multiple-input signature register.
//   clk, rst  : clock, asynchronous active-high reset (sig -> 0)
//   clear     : synchronous clear to 0 (wins over enable)
//   enable    : fold taps into the signature on this edge
//   taps[3:0] : {outd, outc, outb, outa}, sampled raw at the edge
//   sig       : current signature
//   sig_next  : value sig takes on the next enabled edge
module pack_misr32
    import pack_test_pkg::*;
#(
    parameter logic [31:0] POLY = MISR_POLY_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        enable,
    input  logic [3:0]  taps,
    output logic [31:0] sig,
    output logic [31:0] sig_next
);

    assign sig_next = misr_next(sig, taps, POLY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= 32'h0;
        end else if (clear) begin
            sig <= 32'h0;
        end else if (enable) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/pack_stim_monitor.sv
// Stimulus generator and signature monitor for the ice40 packing-test
// register designs. A run is: hold the DUT in reset, drive LFSR stimulus for
// NUM_CYCLES cycles, drain two cycles, then publish the 32-bit signature.
//   clk, rst        : clock, asynchronous active-high reset
//   start           : launch a run (only looked at in IDLE)
//   busy            : a run is in progress (any state but IDLE)
//   done            : one-cycle pulse while in DONE
//   signature[31:0] : final signature, held until the next accepted start
//   dut_cen/rst/ina/inb : stimulus to the design under test
//   outa..outd      : design taps, compacted into signature bits 0..3
//
// Handshake: start is accepted on an edge where state is IDLE and start is 1;
// busy rises the next cycle and stays up through DONE; done pulses once per
// completed run, with signature already valid in that cycle.
module pack_stim_monitor
    import pack_test_pkg::*;
#(
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int          NUM_CYCLES = 256,
    parameter int          RST_CYCLES = 2,
    parameter bit          CEN_RANDOM = 1'b1,
    parameter logic [31:0] MISR_POLY  = MISR_POLY_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] signature,
    output logic        dut_cen,
    output logic        dut_rst,
    output logic        dut_ina,
    output logic        dut_inb,
    input  logic        outa,
    input  logic        outb,
    input  logic        outc,
    input  logic        outd
);

    localparam logic [15:0] RUN_LAST = 16'(NUM_CYCLES - 1);
    localparam logic [7:0]  RST_LAST = 8'(RST_CYCLES - 1);

    state_t      state;
    logic [15:0] lfsr;
    logic [15:0] run_cnt;   // RUN cycle count, reused for the two DRAIN cycles
    logic [7:0]  rst_cnt;
    logic [31:0] sig;
    logic [31:0] sig_next;
    logic        start_accept;
    logic        misr_en;

    assign start_accept = (state == IDLE) && start;
    assign misr_en      = (state == RUN) || (state == DRAIN);

    pack_misr32 #(
        .POLY(MISR_POLY)
    ) u_misr (
        .clk     (clk),
        .rst     (rst),
        .clear   (start_accept),
        .enable  (misr_en),
        .taps    ({outd, outc, outb, outa}),
        .sig     (sig),
        .sig_next(sig_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            lfsr      <= SEED;
            run_cnt   <= 16'h0;
            rst_cnt   <= 8'h0;
            signature <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= DUT_RST;
                        lfsr      <= SEED;
                        run_cnt   <= 16'h0;
                        rst_cnt   <= 8'h0;
                        signature <= 32'h0;
                    end
                end
                DUT_RST: begin
                    if (rst_cnt == RST_LAST) begin
                        state   <= RUN;
                        run_cnt <= 16'h0;
                    end else begin
                        rst_cnt <= rst_cnt + 8'h1;
                    end
                end
                RUN: begin
                    lfsr <= lfsr_next(lfsr);
                    if (run_cnt == RUN_LAST) begin
                        state   <= DRAIN;
                        run_cnt <= 16'h0;
                    end else begin
                        run_cnt <= run_cnt + 16'h1;
                    end
                end
                DRAIN: begin
                    if (run_cnt == 16'h1) begin
                        state     <= DONE;
                        run_cnt   <= 16'h0;
                        // The DONE entry edge is also the final compaction,
                        // so publish the post-update value.
                        signature <= sig_next;
                    end else begin
                        run_cnt <= run_cnt + 16'h1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Stimulus is a pure decode of state and LFSR so an asynchronous reset
    // silences the DUT inputs in the same cycle.
    always_comb begin
        dut_cen = 1'b0;
        dut_rst = 1'b0;
        dut_ina = 1'b0;
        dut_inb = 1'b0;
        case (state)
            DUT_RST: begin
                dut_rst = 1'b1;
                dut_cen = 1'b1;
            end
            RUN: begin
                dut_ina = lfsr[0];
                dut_inb = lfsr[1];
                dut_cen = CEN_RANDOM ? (lfsr[2] | lfsr[3]) : 1'b1;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

endmodule
